// File: rtl/sipo_deframer.sv
// Purpose: rebuilds WIDTH-bit words from a 1-bit serial stream aligned by a frame_start strobe.
// Latency: 0 cycles; the word is visible right after the edge that samples its last bit.
// Backpressure: one-deep valid/ready output; a word completing while the output is held is dropped and sets sticky overflow.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   serial_in           serial data bit, sampled only when serial_valid=1
//   serial_valid        qualifies serial_in and frame_start
//   frame_start         marks the first bit of a word; restarts a partial word (resync)
//   data_out/data_valid assembled word and its valid flag; data_out stable while valid
//   data_ready          consumer accept; transfer on data_valid && data_ready
//   overflow            sticky, a completed word was dropped
//   resync              one-cycle pulse, a partial word was discarded
//   bit_count           bits collected in the current frame
//   parity_err          (only with SIPO_DEFRAMER_PARITY_EN) even-parity failure of the held word
//
// Optional feature macro: SIPO_DEFRAMER_PARITY_EN adds a trailing even-parity bit to every
// frame (frame = WIDTH+1 bits) and the parity_err output.

module sipo_deframer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  serial_in,
    input  logic                                  serial_valid,
    input  logic                                  frame_start,
    output logic [WIDTH-1:0]                      data_out,
    output logic                                  data_valid,
    input  logic                                  data_ready,
    output logic                                  overflow,
    output logic                                  resync,
`ifdef SIPO_DEFRAMER_PARITY_EN
    output logic                                  parity_err,
`endif
`ifdef SIPO_DEFRAMER_PARITY_EN
    output logic [$clog2(WIDTH+2)-1:0]            bit_count
`else
    output logic [$clog2(WIDTH+1)-1:0]            bit_count
`endif
);

`ifdef SIPO_DEFRAMER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               dvld_q, dvld_d;
    logic               ovf_q, ovf_d;
    logic               resync_q, resync_d;
    logic               perr_q, perr_d;
    logic [WIDTH-1:0]   word;
    logic               word_perr;

    // One shift step in the configured bit order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST) begin
            return {cur[WIDTH-2:0], b};
        end else begin
            return {b, cur[WIDTH-1:1]};
        end
    endfunction

    // Word presented on the completing edge. With parity the final bit is the
    // parity bit, so the data is already fully in the shift register.
    always_comb begin
`ifdef SIPO_DEFRAMER_PARITY_EN
        word      = shift_q;
        word_perr = (^shift_q) ^ serial_in;
`else
        word      = shift_in(shift_q, serial_in);
        word_perr = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        // A held word leaves on ready; a completion below may refill it on the same edge.
        dvld_d   = dvld_q & ~data_ready;
        ovf_d    = ovf_q;
        resync_d = 1'b0;
        perr_d   = perr_q;

        if (serial_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        shift_d = shift_in('0, serial_in);
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (frame_start) begin
                        // Early frame_start: drop the partial word and restart on this bit.
                        shift_d  = shift_in('0, serial_in);
                        cnt_d    = CW'(1);
                        resync_d = 1'b1;
                    end else if (cnt_q == CW'(FRAME_LEN - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        shift_d = '0;
                        if (!dvld_q || data_ready) begin
                            dout_d = word;
                            dvld_d = 1'b1;
                            perr_d = word_perr;
                        end else begin
                            ovf_d  = 1'b1;
                        end
                    end else begin
                        shift_d = shift_in(shift_q, serial_in);
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            dvld_q   <= 1'b0;
            ovf_q    <= 1'b0;
            resync_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dvld_q   <= dvld_d;
            ovf_q    <= ovf_d;
            resync_q <= resync_d;
            perr_q   <= perr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dvld_q;
    assign overflow   = ovf_q;
    assign resync     = resync_q;
    assign bit_count  = cnt_q;
`ifdef SIPO_DEFRAMER_PARITY_EN
    assign parity_err = perr_q;
`else
    // Parity state is only observable in the parity build.
    logic unused_perr;
    assign unused_perr = perr_q ^ word_perr;
`endif

endmodule

// File: tb/tb_sipo_deframer.sv
`timescale 1ns/1ps
module tb_sipo_deframer;
    localparam int W = 8;
`ifdef SIPO_DEFRAMER_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         serial_in = 1'b0;
    logic         serial_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic         data_ready = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         overflow;
    logic         resync;
    logic [3:0]   bit_count;
`ifdef SIPO_DEFRAMER_PARITY_EN
    logic         parity_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .overflow     (overflow),
        .resync       (resync),
`ifdef SIPO_DEFRAMER_PARITY_EN
        .parity_err   (parity_err),
`endif
        .bit_count    (bit_count)
    );

    typedef struct {
        logic         rst, sv, fs, sin, rdy;
        logic         edv;
        logic [W-1:0] edo;
        logic         eovf, ers;
        logic [3:0]   ecnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the active edge.
    task automatic step(input logic r, input logic sv, input logic fs, input logic b, input logic rdy);
        rst = r; serial_valid = sv; frame_start = fs; serial_in = b; data_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Bit k of a frame carrying word w, MSB first, trailing even parity if enabled.
    function automatic logic frame_bit(input logic [W-1:0] w, input int k);
        if (k < W) return w[W-1-k];
        return ^w;
    endfunction

    function automatic logic [3:0] cnt_after(input int k);
        return (k == FLEN - 1) ? 4'd0 : 4'(k + 1);
    endfunction

    task automatic send_word(input logic [W-1:0] w, input logic rdy);
        for (int k = 0; k < FLEN; k++) step(1'b0, 1'b1, k == 0, frame_bit(w, k), rdy);
    endtask

    task automatic add(input logic r, input logic sv, input logic fs, input logic b, input logic rdy,
                       input logic edv, input logic [W-1:0] edo, input logic eovf, input logic ers,
                       input logic [3:0] ecnt);
        vec_t v;
        v.rst = r; v.sv = sv; v.fs = fs; v.sin = b; v.rdy = rdy;
        v.edv = edv; v.edo = edo; v.eovf = eovf; v.ers = ers; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    // Behavioural reference state for the random run.
    int           mbits[$];
    logic [W-1:0] mword;
    logic         mvld, movf, mrs, mperr;

    initial begin
        // ---------------- table: reset, basic word, stall/overflow ----------------
        add(1, 0, 0, 0, 0, 0, '0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, '0, 0, 0, 0);
        for (int k = 0; k < FLEN; k++)
            add(0, 1, k == 0, frame_bit(8'hAA, k), 1, k == FLEN - 1, 8'hAA, 0, 0, cnt_after(k));
        add(0, 0, 0, 0, 1, 0, 8'hAA, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'hAA, 0, 0, 0);
        for (int k = 0; k < FLEN; k++)
            add(0, 1, k == 0, frame_bit(8'hAA, k), 0, k == FLEN - 1, 8'hAA, 0, 0, cnt_after(k));
        for (int k = 0; k < FLEN; k++)
            add(0, 1, k == 0, frame_bit(8'h55, k), 0, 1, 8'hAA, k == FLEN - 1, 0, cnt_after(k));
        add(0, 0, 0, 0, 1, 0, 8'hAA, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 8'hAA, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].sv, tbl[i].fs, tbl[i].sin, tbl[i].rdy);
            chk($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(tbl[i].edv));
            if (tbl[i].edv) chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(tbl[i].edo));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].eovf));
            chk($sformatf("vec%0d_resync", i), 32'(resync), 32'(tbl[i].ers));
            chk($sformatf("vec%0d_cnt", i), 32'(bit_count), 32'(tbl[i].ecnt));
        end

        // ---------------- resync ----------------
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        step(0, 1, 0, 1, 1);
        step(0, 1, 0, 1, 1);
        chk("resync_partial_cnt", 32'(bit_count), 32'd3);
        for (int k = 0; k < FLEN; k++) begin
            step(0, 1, k == 0, frame_bit(8'hC3, k), 1);
            if (k == 0) begin
                chk("resync_pulse", 32'(resync), 32'd1);
                chk("resync_restart_cnt", 32'(bit_count), 32'd1);
            end else begin
                chk($sformatf("resync_quiet%0d", k), 32'(resync), 32'd0);
            end
        end
        chk("resync_valid", 32'(data_valid), 32'd1);
        chk("resync_data", 32'(data_out), 32'hC3);
        chk("resync_ovf", 32'(overflow), 32'd0);

        // ---------------- ignored bits and gaps ----------------
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 1'(k), 0);
        chk("idle_ignore_cnt", 32'(bit_count), 32'd0);
        chk("idle_ignore_valid", 32'(data_valid), 32'd0);
        for (int k = 0; k < FLEN; k++) begin
            step(0, 1, k == 0, frame_bit(8'h96, k), 0);
            step(0, 0, 1, 1, 0);
            chk($sformatf("gap_cnt%0d", k), 32'(bit_count), 32'(cnt_after(k)));
        end
        chk("gap_valid", 32'(data_valid), 32'd1);
        chk("gap_data", 32'(data_out), 32'h96);

        // ---------------- complete on the same edge as a transfer ----------------
        step(1, 0, 0, 0, 0);
        send_word(8'h11, 0);
        chk("hold11_data", 32'(data_out), 32'h11);
        for (int k = 0; k < FLEN; k++) step(0, 1, k == 0, frame_bit(8'h22, k), k == FLEN - 1);
        chk("simul_valid", 32'(data_valid), 32'd1);
        chk("simul_data", 32'(data_out), 32'h22);
        chk("simul_ovf", 32'(overflow), 32'd0);

        // ---------------- reset mid-word ----------------
        for (int k = 0; k < 4; k++) step(0, 1, k == 0, frame_bit(8'hF0, k), 0);
        chk("midword_cnt", 32'(bit_count), 32'd4);
        step(1, 0, 0, 0, 0);
        chk("midrst_cnt", 32'(bit_count), 32'd0);
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        send_word(8'hF0, 0);
        chk("after_rst_valid", 32'(data_valid), 32'd1);
        chk("after_rst_data", 32'(data_out), 32'hF0);

`ifdef SIPO_DEFRAMER_PARITY_EN
        // ---------------- parity ----------------
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < W; k++) step(0, 1, k == 0, frame_bit(8'hAA, k), 1);
        step(0, 1, 0, 0, 1);
        chk("par_aa_data", 32'(data_out), 32'hAA);
        chk("par_aa_err", 32'(parity_err), 32'd0);
        for (int k = 0; k < W; k++) step(0, 1, k == 0, frame_bit(8'hAB, k), 1);
        step(0, 1, 0, 0, 1);
        chk("par_ab_data", 32'(data_out), 32'hAB);
        chk("par_ab_err", 32'(parity_err), 32'd1);
`endif

        // ---------------- randomized run against a frame-level model ----------------
        step(1, 0, 0, 0, 0);
        mbits.delete(); mword = '0; mvld = 0; movf = 0; mrs = 0; mperr = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r, sv, fs, b, rdy, free, par;
            logic [W-1:0] w;
            r   = ($urandom_range(0, 199) == 0);
            sv  = ($urandom_range(0, 3) != 0);
            fs  = ($urandom_range(0, 9) == 0);
            b   = 1'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            mrs = 0;
            if (r) begin
                mbits.delete(); mword = '0; mvld = 0; movf = 0; mperr = 0;
            end else begin
                free = !mvld || rdy;
                if (mvld && rdy) mvld = 0;
                if (sv) begin
                    if (fs) begin
                        if (mbits.size() > 0) mrs = 1;
                        mbits.delete();
                        mbits.push_back(int'(b));
                    end else if (mbits.size() > 0) begin
                        mbits.push_back(int'(b));
                        if (mbits.size() == FLEN) begin
                            w = '0;
                            for (int i = 0; i < W; i++) w = W'((w << 1) | W'(mbits[i]));
                            par = 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
                            par = (^w) ^ 1'(mbits[W]);
`endif
                            if (free) begin
                                mword = w; mvld = 1; mperr = par;
                            end else begin
                                movf = 1;
                            end
                            mbits.delete();
                        end
                    end
                end
            end
            step(r, sv, fs, b, rdy);
            chk($sformatf("rnd%0d_valid", c), 32'(data_valid), 32'(mvld));
            if (mvld) chk($sformatf("rnd%0d_data", c), 32'(data_out), 32'(mword));
            chk($sformatf("rnd%0d_ovf", c), 32'(overflow), 32'(movf));
            chk($sformatf("rnd%0d_resync", c), 32'(resync), 32'(mrs));
            chk($sformatf("rnd%0d_cnt", c), 32'(bit_count), 32'(mbits.size()));
`ifdef SIPO_DEFRAMER_PARITY_EN
            if (mvld) chk($sformatf("rnd%0d_perr", c), 32'(parity_err), 32'(mperr));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
